aeolus_alu_datapath: RTL and testbench

AEOLUS_ALU_DATAPATH -- requirements
Module: aeolus_alu_datapath

---
 rtl/aeolus_alu_datapath.sv | 92 +++++++++
 tb/tb_aeolus_alu_datapath.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/aeolus_alu_datapath.sv
// ALU and accumulator datapath. The ALU is combinational and feeds an
// accumulator/overflow register that loads when any operation strobe is active.
module aeolus_alu_datapath #(
  parameter int unsigned INPUT_DATA_WIDTH  = 4,
  parameter int unsigned OUTPUT_DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ADD,
  input  logic                         SUB,
  input  logic                         AND,
  input  logic                         OR,
  input  logic                         XOR,
  input  logic                         INV,
  input  logic                         CLR,
  input  logic                         SNZA,
  input  logic                         SNZS,
  input  logic                         SF,
  input  logic [OUTPUT_DATA_WIDTH-1:0] shiftOut,
  input  logic [INPUT_DATA_WIDTH-1:0]  Aout,
  input  logic [INPUT_DATA_WIDTH-1:0]  Bout,
  output logic [OUTPUT_DATA_WIDTH-1:0] aluOut,
  output logic [OUTPUT_DATA_WIDTH-1:0] ACCout,
  output logic                         OF
);

  localparam int unsigned OW = OUTPUT_DATA_WIDTH;

  logic          add_en;
  logic          snz_sel;
  logic          acc_en;
  logic          carry;
  logic [OW-1:0] in1;
  logic [OW-1:0] in2;
  logic [OW-1:0] alu_res;
  logic [OW:0]   sum_ext;
  logic [OW-1:0] acc_q;
  logic [OW-1:0] acc_d;
  logic          of_q;
  logic          of_d;

  // A conditional shift-add only adds when its shift-flag condition holds.
  assign add_en  = ADD | (SNZA & SF) | (SNZS & ~SF);
  assign snz_sel = SNZA | SNZS;
  assign acc_en  = add_en | SUB | AND | OR | XOR | INV | CLR;

  assign in1     = snz_sel ? acc_q    : OW'(Aout);
  assign in2     = snz_sel ? shiftOut : OW'(Bout);
  assign sum_ext = {1'b0, in1} + {1'b0, in2};

  // Priority-encoded ALU: CLR > add > SUB > AND > OR > XOR > INV.
  always_comb begin
    alu_res = '0;
    carry   = 1'b0;
    if (CLR) begin
      alu_res = '0;
      carry   = 1'b0;
    end else if (add_en) begin
      alu_res = sum_ext[OW-1:0];
      carry   = sum_ext[OW];
    end else if (SUB) begin
      alu_res = in1 - in2;
      carry   = (in1 < in2);
    end else if (AND) begin
      alu_res = in1 & in2;
    end else if (OR) begin
      alu_res = in1 | in2;
    end else if (XOR) begin
      alu_res = in1 ^ in2;
    end else if (INV) begin
      alu_res = ~in1;
    end
  end

  assign acc_d = acc_en ? alu_res : acc_q;
  assign of_d  = acc_en ? carry   : of_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      of_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      of_q  <= of_d;
    end
  end

  assign aluOut = alu_res;
  assign ACCout = acc_q;
  assign OF     = of_q;

endmodule

// File: tb/tb_aeolus_alu_datapath.sv
// Self-checking bench: directed scenarios plus randomized strobes compared
// against an arithmetic reference model of the ALU and accumulator.
module tb_aeolus_alu_datapath;

  localparam int unsigned IW = 4;
  localparam int unsigned OW = 8;

  // Operation vector bit positions
  localparam int unsigned B_ADD  = 0;
  localparam int unsigned B_SUB  = 1;
  localparam int unsigned B_AND  = 2;
  localparam int unsigned B_OR   = 3;
  localparam int unsigned B_XOR  = 4;
  localparam int unsigned B_INV  = 5;
  localparam int unsigned B_CLR  = 6;
  localparam int unsigned B_SNZA = 7;
  localparam int unsigned B_SNZS = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ADD, SUB, AND, OR, XOR, INV, CLR, SNZA, SNZS, SF;
  logic [OW-1:0] shiftOut;
  logic [IW-1:0] Aout, Bout;
  logic [OW-1:0] aluOut;
  logic [OW-1:0] ACCout;
  logic          OF;

  int checks   = 0;
  int failures = 0;
  int acc_m    = 0;
  int of_m     = 0;

  aeolus_alu_datapath #(
    .INPUT_DATA_WIDTH (IW),
    .OUTPUT_DATA_WIDTH(OW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ADD     (ADD),
    .SUB     (SUB),
    .AND     (AND),
    .OR      (OR),
    .XOR     (XOR),
    .INV     (INV),
    .CLR     (CLR),
    .SNZA    (SNZA),
    .SNZS    (SNZS),
    .SF      (SF),
    .shiftOut(shiftOut),
    .Aout    (Aout),
    .Bout    (Bout),
    .aluOut  (aluOut),
    .ACCout  (ACCout),
    .OF      (OF)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference of the ALU result, carry and accumulator enable.
  task automatic ref_alu(input logic [8:0] op, input logic sf_v, input int a, input int b,
                         input int sh, output int res, output int cy, output bit en);
    bit addin;
    int i1, i2;
    addin = op[B_ADD] | (op[B_SNZA] & sf_v) | (op[B_SNZS] & ~sf_v);
    if (op[B_SNZA] | op[B_SNZS]) begin
      i1 = acc_m; i2 = sh;
    end else begin
      i1 = a; i2 = b;
    end
    cy = 0;
    res = 0;
    if (op[B_CLR])      res = 0;
    else if (addin)     begin res = (i1 + i2) % 256; cy = (i1 + i2 > 255) ? 1 : 0; end
    else if (op[B_SUB]) begin res = (i1 - i2 + 256) % 256; cy = (i1 < i2) ? 1 : 0; end
    else if (op[B_AND]) res = i1 & i2;
    else if (op[B_OR])  res = i1 | i2;
    else if (op[B_XOR]) res = i1 ^ i2;
    else if (op[B_INV]) res = 255 - i1;
    en = addin | op[B_SUB] | op[B_AND] | op[B_OR] | op[B_XOR] | op[B_INV] | op[B_CLR];
  endtask

  // Drive one cycle, check aluOut combinationally, then ACCout/OF after the edge.
  task automatic step(input string tag, input logic [8:0] op, input logic sf_v,
                      input logic [IW-1:0] a, input logic [IW-1:0] b,
                      input logic [OW-1:0] sh, input logic rst);
    int res, cy;
    bit en;
    reset = rst;
    ADD = op[B_ADD]; SUB = op[B_SUB]; AND = op[B_AND]; OR = op[B_OR];
    XOR = op[B_XOR]; INV = op[B_INV]; CLR = op[B_CLR];
    SNZA = op[B_SNZA]; SNZS = op[B_SNZS];
    SF = sf_v; Aout = a; Bout = b; shiftOut = sh;
    #1;
    ref_alu(op, sf_v, int'(a), int'(b), int'(sh), res, cy, en);
    check_val({tag, "_alu"}, 32'(aluOut), 32'(res));
    @(posedge clk);
    #1;
    if (rst) begin
      acc_m = 0; of_m = 0;
    end else if (en) begin
      acc_m = res; of_m = cy;
    end
    check_val({tag, "_acc"}, 32'(ACCout), 32'(acc_m));
    check_val({tag, "_of"}, 32'(OF), 32'(of_m));
  endtask

  function automatic logic [8:0] opv(input int unsigned bitpos);
    logic [8:0] v;
    v = '0;
    v[bitpos] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [8:0] op;
    // Reset with ADD held and A=B=0xF
    step("rst0", opv(B_ADD), 1'b0, 4'hF, 4'hF, 8'h00, 1'b1);
    step("rst1", opv(B_ADD), 1'b0, 4'hF, 4'hF, 8'h00, 1'b1);
    check_val("rst_acc_const", 32'(ACCout), 32'h00);
    check_val("rst_of_const", 32'(OF), 32'h0);

    step("add", opv(B_ADD), 1'b0, 4'h9, 4'h8, 8'h00, 1'b0);
    check_val("add_const", 32'(ACCout), 32'h11);
    step("sub", opv(B_SUB), 1'b0, 4'h3, 4'h5, 8'h00, 1'b0);
    check_val("sub_const", 32'(ACCout), 32'hFE);
    check_val("sub_of_const", 32'(OF), 32'h1);

    step("and", opv(B_AND), 1'b0, 4'hA, 4'h6, 8'h00, 1'b0);
    check_val("and_const", 32'(ACCout), 32'h02);
    step("or", opv(B_OR), 1'b0, 4'hA, 4'h6, 8'h00, 1'b0);
    check_val("or_const", 32'(ACCout), 32'h0E);
    step("xor", opv(B_XOR), 1'b0, 4'hA, 4'h6, 8'h00, 1'b0);
    check_val("xor_const", 32'(ACCout), 32'h0C);
    step("inv", opv(B_INV), 1'b0, 4'hA, 4'h6, 8'h00, 1'b0);
    check_val("inv_const", 32'(ACCout), 32'hF5);
    check_val("inv_of_const", 32'(OF), 32'h0);

    // ~0x0F gives ACCout = 0xF0 for the conditional-add sequence
    step("inv_f", opv(B_INV), 1'b0, 4'hF, 4'h0, 8'h00, 1'b0);
    check_val("acc_f0_const", 32'(ACCout), 32'hF0);
    step("snza_t", opv(B_SNZA), 1'b1, 4'h0, 4'h0, 8'h20, 1'b0);
    check_val("snza_t_const", 32'(ACCout), 32'h10);
    check_val("snza_t_of_const", 32'(OF), 32'h1);
    step("snza_f", opv(B_SNZA), 1'b0, 4'h0, 4'h0, 8'h20, 1'b0);
    check_val("snza_f_const", 32'(ACCout), 32'h10);
    step("snzs_t", opv(B_SNZS), 1'b0, 4'h0, 4'h0, 8'h20, 1'b0);
    check_val("snzs_t_const", 32'(ACCout), 32'h30);
    check_val("snzs_t_of_const", 32'(OF), 32'h0);

    step("clr_add", opv(B_CLR) | opv(B_ADD), 1'b0, 4'hF, 4'hF, 8'h00, 1'b0);
    check_val("clr_add_const", 32'(ACCout), 32'h00);
    step("add_sub", opv(B_ADD) | opv(B_SUB), 1'b0, 4'h2, 4'h1, 8'h00, 1'b0);
    check_val("add_sub_const", 32'(ACCout), 32'h03);
    for (int i = 0; i < 3; i++) step("idle", 9'h000, 1'b1, 4'h7, 4'h3, 8'h55, 1'b0);
    check_val("idle_const", 32'(ACCout), 32'h03);

    // Reset mid-sequence discards a pending add
    step("rst_mid", opv(B_ADD), 1'b0, 4'hF, 4'h1, 8'h00, 1'b1);
    step("post_rst", opv(B_ADD), 1'b0, 4'h4, 4'h5, 8'h00, 1'b0);
    check_val("post_rst_const", 32'(ACCout), 32'h09);

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 9; k++) op[k] = ($urandom_range(0, 4) == 0);
      step("rnd", op, 1'($urandom()), 4'($urandom()), 4'($urandom()), 8'($urandom()),
           ($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
